// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: NOP encoding, default reset vector and the
// {pc, inst} entry carried from fetch to decode.
package rv32i_pkg;

  localparam logic [31:0] RV32I_NOP    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_fetch_if.sv
// Instruction memory request/response bus between fetch (master) and imem (slave).
interface rv32i_fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/rv32i_fetch_fifo.sv
// Small synchronous FIFO with flush; used both as the PC side queue and the
// output buffer of the fetch stage.
module rv32i_fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  // Status flags and guarded push/pop strobes.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; reset and flush empty the queue.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage: owns the PC, issues in-order word requests,
// tags responses with their PC and buffers them for decode.
module rv32i_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_VECTOR,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rv32i_fetch_if.master        imem,
  input  logic                 i_redirect,
  input  logic [31:0]          i_redirect_pc,
  input  logic                 i_stall,
  output logic                 o_valid,
  output logic [31:0]          o_inst,
  output logic [31:0]          o_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] discard;
  logic [CW:0]   occupancy;
  logic          granted;
  logic          drop_rsp;
  logic          keep_rsp;
  logic          pop_out;

  logic [31:0]   side_pc;
  logic [CW-1:0] side_count;
  logic          side_empty;
  logic          side_full;

  fetch_entry_t  buf_din;
  fetch_entry_t  buf_head;
  logic [CW-1:0] buf_count;
  logic          buf_empty;
  logic          buf_full;

  // Request issue and response classification.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    imem.req         = 1'b0;
    imem.addr        = pc_q;
    occupancy        = {1'b0, buf_count} + {1'b0, outstanding};
    granted          = 1'b0;
    drop_rsp         = 1'b0;
    keep_rsp         = 1'b0;
    buf_din          = '{pc: side_pc, inst: imem.rdata};
    // Buffered plus in-flight work never exceeds the buffer, so every response has a slot.
    imem.req         = !i_rst && !i_redirect && (occupancy < (CW+1)'(FIFO_DEPTH));
    granted          = imem.req && imem.gnt;
    drop_rsp         = imem.rvalid && (discard != '0);
    keep_rsp         = imem.rvalid && (discard == '0) && !i_redirect;
    outstanding_next = outstanding + CW'(granted) - CW'(imem.rvalid);
  end

  // Decode-facing outputs; a redirect hides the buffer in the cycle it flushes it.
  always_comb begin
    o_valid = !buf_empty && !i_redirect;
    pop_out = o_valid && !i_stall;
    o_inst  = o_valid ? buf_head.inst : RV32I_NOP;
    o_pc    = o_valid ? buf_head.pc   : pc_q;
  end

  // PC, in-flight and discard counters; redirect overrides normal advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q        <= word_align(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (i_redirect) begin
        pc_q    <= word_align(i_redirect_pc);
        // Everything still in flight after this edge is stale: the remaining
        // discards plus the live requests, which together equal outstanding_next.
        discard <= outstanding_next;
      end else begin
        if (granted)  pc_q    <= pc_q + 32'd4;
        if (drop_rsp) discard <= discard - 1'b1;
      end
    end
  end

  rv32i_fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (logic [31:0])
  ) u_side_q (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_redirect),
    .push  (granted),
    .din   (pc_q),
    .pop   (keep_rsp),
    .dout  (side_pc),
    .count (side_count),
    .empty (side_empty),
    .full  (side_full)
  );

  rv32i_fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_out_buf (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_redirect),
    .push  (keep_rsp),
    .din   (buf_din),
    .pop   (pop_out),
    .dout  (buf_head),
    .count (buf_count),
    .empty (buf_empty),
    .full  (buf_full)
  );

  a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (i_rst)
    imem.rvalid |-> (outstanding != '0));
  a_outstanding_cap: assert property (@(posedge i_clk) disable iff (i_rst)
    outstanding <= CW'(FIFO_DEPTH));
  a_side_tracks: assert property (@(posedge i_clk) disable iff (i_rst)
    (side_count <= outstanding) && !(keep_rsp && side_empty) && !(granted && side_full));
  a_buf_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(keep_rsp && buf_full));

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch with a latency-configurable in-order memory model.
module tb_rv32i_fetch;
  import rv32i_pkg::*;

  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;

  logic        w_rst = 1'b1;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_pend = 1'b0;
  logic [31:0] w_pend_addr = 32'h0;

  rv32i_fetch_if bus ();
  rv32i_fetch_if wbus ();

  rv32i_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .imem(bus), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .i_stall(stall),
    .o_valid(valid), .o_inst(inst), .o_pc(pc)
  );

  rv32i_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
    .i_clk(clk), .i_rst(w_rst), .imem(wbus), .i_redirect(1'b0),
    .i_redirect_pc(32'h0), .i_stall(1'b0),
    .o_valid(w_valid), .o_inst(w_inst), .o_pc(w_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t q[$];
  int       cyc = 0;
  int       lat = 1;
  logic     gnt_en = 1'b1;
  int       tests = 0;
  int       fails = 0;

  // One clock cycle: drive memory inputs for the coming edge, then step past it.
  task automatic tick();
    mem_req_t r;
    #1;
    if (rst) begin
      q.delete();
      bus.rvalid = 1'b0;
      bus.rdata  = 32'h0;
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      bus.rvalid = 1'b1;
      bus.rdata  = q[0].addr ^ MASK;
      void'(q.pop_front());
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = 32'hDEAD_BEEF;
    end
    bus.gnt = gnt_en;
    if (bus.req && bus.gnt) begin
      r.addr = bus.addr;
      r.due  = cyc + lat;
      q.push_back(r);
    end
    if (w_rst) begin
      wbus.rvalid = 1'b0;
      wbus.rdata  = 32'h0;
      w_pend      = 1'b0;
    end else begin
      wbus.rvalid = w_pend;
      wbus.rdata  = w_pend_addr ^ MASK;
      w_pend      = wbus.req && wbus.gnt;
      w_pend_addr = wbus.addr;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Step until o_valid is seen or the budget runs out.
  task automatic wait_valid(input int max, output int waited, output logic ok);
    waited = 0;
    while (!valid && waited < max) begin
      tick();
      waited++;
    end
    ok = valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; gnt_en = 1'b1; lat = 1;
    tick(); tick();
    tests++; if (bus.req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.req); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (inst !== RV32I_NOP) begin fails++; $display("FAIL reset_inst: got %h want %h", inst, RV32I_NOP); end
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    tests++; if (bus.addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 00000000", bus.addr); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    rst = 1'b0;
    #1;
    tests++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
      fails++; $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=00000000", bus.req, bus.addr); end
    tick();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL stream_latency_early: got valid=%b want 0", valid); end
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      exp_pc = 32'(i * 4);
      tests++; if (valid !== 1'b1 || pc !== exp_pc || inst !== (exp_pc ^ MASK)) begin
        fails++; $display("FAIL stream_%0d: got valid=%b pc=%h inst=%h want valid=1 pc=%h inst=%h",
                          i, valid, pc, inst, exp_pc, exp_pc ^ MASK); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (valid !== 1'b1 || pc !== 32'd28 || inst !== (32'd28 ^ MASK)) begin
        fails++; $display("FAIL stall_hold_%0d: got valid=%b pc=%h inst=%h want valid=1 pc=0000001c", i, valid, pc, inst); end
      tests++; if (bus.req !== (i == 0)) begin
        fails++; $display("FAIL stall_req_%0d: got %b want %b", i, bus.req, (i == 0)); end
    end
    stall = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_pc = 32'd28 + 32'(i * 4);
      tests++; if (valid !== 1'b1 || pc !== exp_pc || inst !== (exp_pc ^ MASK)) begin
        fails++; $display("FAIL stall_resume_%0d: got valid=%b pc=%h want valid=1 pc=%h", i, valid, pc, exp_pc); end
    end
  endtask

  task automatic test_redirect_inflight();
    int   waited;
    logic ok;
    rst = 1'b1; tick(); rst = 1'b0;
    lat = 3; stall = 1'b0;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_1002;
    #1;
    tests++; if (bus.req !== 1'b0 || valid !== 1'b0) begin
      fails++; $display("FAIL redir_during: got req=%b valid=%b want 0 0", bus.req, valid); end
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (bus.req !== 1'b1 || bus.addr !== 32'h0000_1000) begin
      fails++; $display("FAIL redir_addr: got req=%b addr=%h want req=1 addr=00001000", bus.req, bus.addr); end
    wait_valid(20, waited, ok);
    tests++; if (!ok || waited < 3) begin
      fails++; $display("FAIL redir_penalty: got valid=%b after %0d cycles want valid=1 after >=3", ok, waited); end
    tests++; if (pc !== 32'h0000_1000 || inst !== (32'h0000_1000 ^ MASK)) begin
      fails++; $display("FAIL redir_first: got pc=%h inst=%h want pc=00001000", pc, inst); end
    tick();
    wait_valid(10, waited, ok);
    tests++; if (!ok || pc !== 32'h0000_1004) begin
      fails++; $display("FAIL redir_second: got valid=%b pc=%h want valid=1 pc=00001004", ok, pc); end
  endtask

  task automatic test_coincident();
    int          waited;
    logic        ok;
    logic [31:0] exp_pc;
    rst = 1'b1; tick(); rst = 1'b0;
    lat = 2; stall = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    // Steady state here: a response and a grant-ready request land on every edge.
    redirect = 1'b1; redirect_pc = 32'h0000_2003;
    #1;
    tests++; if (valid !== 1'b0 || inst !== RV32I_NOP) begin
      fails++; $display("FAIL coinc_masked: got valid=%b inst=%h want valid=0 inst=%h", valid, inst, RV32I_NOP); end
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (bus.addr !== 32'h0000_2000) begin
      fails++; $display("FAIL coinc_addr: got %h want 00002000", bus.addr); end
    for (int i = 0; i < 4; i++) begin
      wait_valid(10, waited, ok);
      exp_pc = 32'h0000_2000 + 32'(i * 4);
      tests++; if (!ok || pc !== exp_pc || inst !== (exp_pc ^ MASK)) begin
        fails++; $display("FAIL coinc_stream_%0d: got valid=%b pc=%h inst=%h want pc=%h", i, ok, pc, inst, exp_pc); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int          waited;
    logic        ok;
    logic [31:0] exp_pc;
    lat = 3;
    for (int i = 0; i < 4; i++) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    tick();
    redirect_pc = 32'h0000_4004;
    #1;
    tests++; if (valid !== 1'b0 || bus.req !== 1'b0) begin
      fails++; $display("FAIL b2b_during: got valid=%b req=%b want 0 0", valid, bus.req); end
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (bus.req !== 1'b1 || bus.addr !== 32'h0000_4004) begin
      fails++; $display("FAIL b2b_addr: got req=%b addr=%h want req=1 addr=00004004", bus.req, bus.addr); end
    for (int i = 0; i < 4; i++) begin
      wait_valid(12, waited, ok);
      exp_pc = 32'h0000_4004 + 32'(i * 4);
      tests++; if (!ok || pc !== exp_pc || inst !== (exp_pc ^ MASK)) begin
        fails++; $display("FAIL b2b_stream_%0d: got valid=%b pc=%h inst=%h want pc=%h", i, ok, pc, inst, exp_pc); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    lat = 3; stall = 1'b1;
    // With depth 4, buffered plus in-flight is capped at 4: two buffered, two outstanding.
    for (int i = 0; i < 5; i++) tick();
    tests++; if (valid !== 1'b1 || pc !== 32'h0 || bus.req !== 1'b0) begin
      fails++; $display("FAIL rmid_pre: got valid=%b pc=%h req=%b want 1 00000000 0", valid, pc, bus.req); end
    rst = 1'b1;
    tick();
    tests++; if (valid !== 1'b0 || bus.req !== 1'b0 || inst !== RV32I_NOP) begin
      fails++; $display("FAIL rmid_reset: got valid=%b req=%b inst=%h want 0 0 %h", valid, bus.req, inst, RV32I_NOP); end
    rst = 1'b0; stall = 1'b0; lat = 1;
    #1;
    tests++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
      fails++; $display("FAIL rmid_restart: got req=%b addr=%h want 1 00000000", bus.req, bus.addr); end
    tick(); tick();
    tests++; if (valid !== 1'b1 || pc !== 32'h0 || inst !== MASK) begin
      fails++; $display("FAIL rmid_first: got valid=%b pc=%h inst=%h want 1 00000000 %h", valid, pc, inst, MASK); end
    tick();
    tests++; if (valid !== 1'b1 || pc !== 32'h4) begin
      fails++; $display("FAIL rmid_second: got valid=%b pc=%h want 1 00000004", valid, pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    w_rst = 1'b1; tick(); w_rst = 1'b0;
    #1;
    tests++; if (wbus.req !== 1'b1 || wbus.addr !== 32'hFFFF_FFF8) begin
      fails++; $display("FAIL wrap_first_req: got req=%b addr=%h want 1 fffffff8", wbus.req, wbus.addr); end
    tick();
    tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL wrap_early: got valid=%b want 0", w_valid); end
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (w_valid !== 1'b1 || w_pc !== exp_pc || w_inst !== (exp_pc ^ MASK)) begin
        fails++; $display("FAIL wrap_%0d: got valid=%b pc=%h inst=%h want 1 %h", i, w_valid, w_pc, w_inst, exp_pc); end
      exp_pc = exp_pc + 32'd4;
    end
    w_rst = 1'b1; tick();
  endtask

  initial begin
    wbus.gnt    = 1'b1;
    wbus.rvalid = 1'b0;
    wbus.rdata  = 32'h0;
    bus.gnt     = 1'b1;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'h0;
    test_reset();
    test_streaming();
    test_stall();
    test_redirect_inflight();
    test_coincident();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
